// File: rtl/corr_window_loader_pkg.sv
// Shared types and defaults for the correlator window loader.
// Optional build macro used across the slice: CORR_WIN_COUNT_EN (adds win_count).
package corr_pkg;

  localparam int TAPS_DEF = 10;
  localparam int W_DEF    = 4;

  typedef enum logic [1:0] {COEF, FILL, RUN} corr_ld_state_t;

endpackage

// File: rtl/corr_window_loader_if.sv
// Bundle of coefficient/sample streams and window outputs for corr_window_loader.
// With CORR_WIN_COUNT_EN defined the bundle also carries win_count.
interface corr_window_loader_if
  import corr_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int W    = W_DEF
);

  logic                coef_start;
  logic                coef_valid;
  logic [W-1:0]        coef_data;
  logic                coef_ready;
  logic                s_valid;
  logic [W-1:0]        s_data;
  logic                s_ready;
  logic [TAPS*W-1:0]   x_flat;
  logic [TAPS*W-1:0]   h_flat;
  logic                win_valid;
  logic                loaded;
`ifdef CORR_WIN_COUNT_EN
  logic [15:0]         win_count;
`endif

  modport master (
`ifdef CORR_WIN_COUNT_EN
    input  win_count,
`endif
    output coef_start, coef_valid, coef_data, s_valid, s_data,
    input  coef_ready, s_ready, x_flat, h_flat, win_valid, loaded
  );

  modport slave (
`ifdef CORR_WIN_COUNT_EN
    output win_count,
`endif
    input  coef_start, coef_valid, coef_data, s_valid, s_data,
    output coef_ready, s_ready, x_flat, h_flat, win_valid, loaded
  );

endinterface

// File: rtl/corr_tap_shreg.sv
// TAPS x W sample window: x_0 sits in the low bits, each shift ages every tap by one.
module corr_tap_shreg
  import corr_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int W    = W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              shift,
  input  logic              clear,
  input  logic [W-1:0]      din,
  output logic [TAPS*W-1:0] q
);

  // Clear wins over shift so a restart never leaves a half-old window behind.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (shift) begin
      q <= {q[(TAPS-1)*W-1:0], din};
    end
  end

endmodule

// File: rtl/corr_window_loader.sv
// Loads the coefficient set and maintains the sliding sample window for the correlator.
// Optional: define CORR_WIN_COUNT_EN to add a saturating win_count on the interface.
module corr_window_loader
  import corr_pkg::*;
#(
  parameter int TAPS  = TAPS_DEF,
  parameter int W     = W_DEF,
  parameter int CNT_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  corr_window_loader_if.slave bus
);

  corr_ld_state_t          state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic                    win, win_next;
  logic                    shift, clear, h_we;
  logic [TAPS-1:0][W-1:0]  h_q;
  logic [TAPS*W-1:0]       x_q;
  logic                    s_accept;

  assign bus.coef_ready = (state == COEF);
  assign bus.s_ready    = (state != COEF) && !bus.coef_start;
  assign bus.loaded     = (state != COEF);
  assign bus.win_valid  = win;
  assign bus.h_flat     = h_q;
  assign bus.x_flat     = x_q;
  assign s_accept       = bus.s_valid && bus.s_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= COEF;
      cnt   <= '0;
      win   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      win   <= win_next;
    end
  end

  // coef_start overrides everything; otherwise cnt tracks words/samples within the current state.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    win_next   = 1'b0;
    shift      = 1'b0;
    clear      = 1'b0;
    h_we       = 1'b0;
    if (bus.coef_start) begin
      state_next = COEF;
      cnt_next   = '0;
      clear      = 1'b1;
    end else begin
      case (state)
        COEF: begin
          if (bus.coef_valid) begin
            h_we = 1'b1;
            if (cnt == CNT_W'(TAPS-1)) begin
              cnt_next   = '0;
              state_next = FILL;
            end else begin
              cnt_next = cnt + CNT_W'(1);
            end
          end
        end
        FILL: begin
          if (s_accept) begin
            shift = 1'b1;
            if (cnt == CNT_W'(TAPS-1)) begin
              cnt_next   = '0;
              state_next = RUN;
              win_next   = 1'b1;
            end else begin
              cnt_next = cnt + CNT_W'(1);
            end
          end
        end
        RUN: begin
          if (s_accept) begin
            shift    = 1'b1;
            win_next = 1'b1;
          end
        end
        default: begin
          state_next = COEF;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0;
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        if (h_we && (cnt == CNT_W'(i))) h_q[i] <= bus.coef_data;
      end
    end
  end

  corr_tap_shreg #(
    .TAPS (TAPS),
    .W    (W)
  ) u_window (
    .clock   (clock),
    .reset_n (reset_n),
    .shift   (shift),
    .clear   (clear),
    .din     (bus.s_data),
    .q       (x_q)
  );

`ifdef CORR_WIN_COUNT_EN
  logic [15:0] win_cnt;

  // Counts pulses on the same edge that raises win_valid, so both are visible together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt <= '0;
    end else if (bus.coef_start) begin
      win_cnt <= '0;
    end else if (win_next && (win_cnt != 16'hFFFF)) begin
      win_cnt <= win_cnt + 16'd1;
    end
  end

  assign bus.win_count = win_cnt;
`endif

endmodule

// File: tb/tb_corr_window_loader.sv
// Randomised bench for corr_window_loader against a window/coefficient-list model.
// Define CORR_WIN_COUNT_EN to also exercise win_count.
module tb_corr_window_loader;
  import corr_pkg::*;

  localparam int TAPS = TAPS_DEF;
  localparam int W    = W_DEF;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  corr_window_loader_if #(.TAPS(TAPS), .W(W)) bus ();

  corr_window_loader #(.TAPS(TAPS), .W(W), .CNT_W(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: a coefficient list being filled, and a window that is valid once TAPS samples arrived.
  logic [W-1:0] mh[TAPS];
  logic [W-1:0] mx[TAPS];
  int m_coefs, m_fill, m_wcount;
  bit m_loaded, m_win;
  logic obs_s_ready, obs_coef_ready, exp_s_ready, exp_coef_ready;

  function automatic logic [TAPS*W-1:0] exp_x();
    logic [TAPS*W-1:0] f;
    for (int i = 0; i < TAPS; i++) f[i*W +: W] = mx[i];
    return f;
  endfunction

  function automatic logic [TAPS*W-1:0] exp_h();
    logic [TAPS*W-1:0] f;
    for (int i = 0; i < TAPS; i++) f[i*W +: W] = mh[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      mh[i] = '0;
      mx[i] = '0;
    end
    m_coefs = 0; m_fill = 0; m_wcount = 0; m_loaded = 0; m_win = 0;
  endtask

  task automatic model_step(input logic st, input logic cv, input logic [W-1:0] cd,
                            input logic sv, input logic [W-1:0] sd);
    m_win = 0;
    if (st) begin
      m_loaded = 0; m_coefs = 0; m_fill = 0; m_wcount = 0;
      for (int i = 0; i < TAPS; i++) mx[i] = '0;
    end else if (!m_loaded) begin
      if (cv) begin
        mh[m_coefs] = cd;
        m_coefs++;
        if (m_coefs == TAPS) begin
          m_loaded = 1; m_fill = 0;
        end
      end
    end else if (sv) begin
      for (int i = TAPS-1; i > 0; i--) mx[i] = mx[i-1];
      mx[0] = sd;
      if (m_fill < TAPS) m_fill++;
      if (m_fill >= TAPS) m_win = 1;
    end
    if (m_win && m_wcount < 65535) m_wcount++;
  endtask

  task automatic drive_cycle(input logic st, input logic cv, input logic [W-1:0] cd,
                             input logic sv, input logic [W-1:0] sd);
    @(negedge clock);
    bus.coef_start = st; bus.coef_valid = cv; bus.coef_data = cd;
    bus.s_valid = sv; bus.s_data = sd;
    #1;
    obs_s_ready = bus.s_ready;
    obs_coef_ready = bus.coef_ready;
    exp_s_ready = m_loaded && !st;
    exp_coef_ready = !m_loaded;
    @(posedge clock);
    model_step(st, cv, cd, sv, sd);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    bus.coef_start = 0; bus.coef_valid = 0; bus.coef_data = '0;
    bus.s_valid = 0; bus.s_data = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic load_random_coefs();
    for (int i = 0; i < TAPS; i++) drive_cycle(0, 1, W'($urandom), 0, '0);
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (bus.x_flat !== '0) begin miscompares++; $display("FAIL reset_x got %h want 0", bus.x_flat); end
    vectors++;
    if (bus.h_flat !== '0) begin miscompares++; $display("FAIL reset_h got %h want 0", bus.h_flat); end
    vectors++;
    if (bus.win_valid !== 1'b0 || bus.loaded !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags win=%b loaded=%b want 0 0", bus.win_valid, bus.loaded);
    end
    vectors++;
    if (bus.coef_ready !== 1'b1 || bus.s_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready coef_ready=%b s_ready=%b want 1 0", bus.coef_ready, bus.s_ready);
    end
  endtask

  task automatic test_load_and_fill();
    logic [TAPS*W-1:0] hc;
    apply_reset();
    for (int i = 0; i < TAPS; i++) hc[i*W +: W] = W'(i+1);
    for (int i = 0; i < TAPS; i++) drive_cycle(0, 1, W'(i+1), 0, '0);
    vectors++;
    if (bus.h_flat !== hc) begin miscompares++; $display("FAIL load_h got %h want %h", bus.h_flat, hc); end
    for (int i = 0; i < TAPS; i++) begin
      drive_cycle(0, 0, '0, 1, W'(i+1));
      vectors++;
      if (bus.win_valid !== (i == TAPS-1)) begin
        miscompares++; $display("FAIL fill_win sample %0d got %b want %b", i+1, bus.win_valid, (i == TAPS-1));
      end
      vectors++;
      if (obs_s_ready !== 1'b1) begin miscompares++; $display("FAIL fill_s_ready got %b want 1", obs_s_ready); end
    end
    vectors++;
    if (bus.x_flat[W-1:0] !== W'(10) || bus.x_flat[9*W +: W] !== W'(1)) begin
      miscompares++; $display("FAIL fill_ends x0=%0d x9=%0d want 10 1", bus.x_flat[W-1:0], bus.x_flat[9*W +: W]);
    end
    vectors++;
    if (bus.x_flat !== exp_x()) begin miscompares++; $display("FAIL fill_x got %h want %h", bus.x_flat, exp_x()); end
    vectors++;
    if (bus.loaded !== 1'b1) begin miscompares++; $display("FAIL fill_loaded got %b want 1", bus.loaded); end
  endtask

  task automatic test_back_to_back();
    for (int v = 11; v <= 13; v++) begin
      drive_cycle(0, 0, '0, 1, W'(v));
      vectors++;
      if (bus.win_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_win value %0d got %b want 1", v, bus.win_valid); end
    end
    vectors++;
    if (bus.x_flat[W-1:0] !== W'(13) || bus.x_flat[9*W +: W] !== W'(4)) begin
      miscompares++; $display("FAIL b2b_ends x0=%0d x9=%0d want 13 4", bus.x_flat[W-1:0], bus.x_flat[9*W +: W]);
    end
    drive_cycle(0, 1, W'(7), 0, '0);
    vectors++;
    if (bus.win_valid !== 1'b0 || bus.x_flat !== exp_x()) begin
      miscompares++; $display("FAIL idle_hold win=%b x=%h want 0 %h", bus.win_valid, bus.x_flat, exp_x());
    end
    vectors++;
    if (bus.h_flat !== exp_h()) begin miscompares++; $display("FAIL run_coef_ignored got %h want %h", bus.h_flat, exp_h()); end
  endtask

  task automatic test_coef_start();
    drive_cycle(1, 0, '0, 1, W'(15));
    vectors++;
    if (obs_s_ready !== 1'b0) begin miscompares++; $display("FAIL start_s_ready got %b want 0", obs_s_ready); end
    vectors++;
    if (bus.x_flat !== '0) begin miscompares++; $display("FAIL start_x got %h want 0", bus.x_flat); end
    vectors++;
    if (bus.coef_ready !== 1'b1 || bus.loaded !== 1'b0 || bus.win_valid !== 1'b0) begin
      miscompares++; $display("FAIL start_state coef_ready=%b loaded=%b win=%b want 1 0 0", bus.coef_ready, bus.loaded, bus.win_valid);
    end
    vectors++;
    if (bus.h_flat !== exp_h()) begin miscompares++; $display("FAIL start_h_kept got %h want %h", bus.h_flat, exp_h()); end
    for (int i = 0; i < TAPS; i++) begin
      drive_cycle(0, 0, '0, 1, W'($urandom));
      vectors++;
      if (bus.win_valid !== 1'b0 || bus.x_flat !== '0) begin
        miscompares++; $display("FAIL start_no_win cycle %0d win=%b x=%h want 0 0", i, bus.win_valid, bus.x_flat);
      end
    end
  endtask

  task automatic test_reset_midload();
    logic [W-1:0] words[TAPS];
    logic [TAPS*W-1:0] hc;
    apply_reset();
    for (int i = 0; i < 5; i++) drive_cycle(0, 1, W'($urandom_range(1, 15)), 0, '0);
    @(negedge clock);
    bus.coef_valid = 0;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (bus.h_flat !== '0 || bus.coef_ready !== 1'b1) begin
      miscompares++; $display("FAIL midload_reset h=%h coef_ready=%b want 0 1", bus.h_flat, bus.coef_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < TAPS; i++) begin
      words[i] = W'($urandom);
      hc[i*W +: W] = words[i];
      drive_cycle(0, 1, words[i], 0, '0);
    end
    vectors++;
    if (bus.h_flat !== hc || bus.loaded !== 1'b1) begin
      miscompares++; $display("FAIL reload_h got %h loaded=%b want %h 1", bus.h_flat, bus.loaded, hc);
    end
  endtask

  task automatic test_fill_gaps();
    int accepted;
    logic sv;
    apply_reset();
    load_random_coefs();
    accepted = 0;
    for (int i = 0; i < 30; i++) begin
      sv = (i % 3 == 2);
      drive_cycle(0, 0, '0, sv, W'($urandom));
      if (sv) accepted++;
      vectors++;
      if (bus.win_valid !== (sv && accepted == TAPS)) begin
        miscompares++; $display("FAIL gap_win cycle %0d got %b want %b", i, bus.win_valid, (sv && accepted == TAPS));
      end
      vectors++;
      if (bus.x_flat !== exp_x()) begin miscompares++; $display("FAIL gap_x cycle %0d got %h want %h", i, bus.x_flat, exp_x()); end
    end
  endtask

  task automatic test_random();
    logic st, cv, sv;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 59) == 0);
      cv = $urandom_range(0, 1);
      sv = ($urandom_range(0, 3) != 0);
      drive_cycle(st, cv, W'($urandom), sv, W'($urandom));
      vectors++;
      if (obs_s_ready !== exp_s_ready || obs_coef_ready !== exp_coef_ready) begin
        miscompares++; $display("FAIL rnd_ready cycle %0d s=%b c=%b want %b %b", i, obs_s_ready, obs_coef_ready, exp_s_ready, exp_coef_ready);
      end
      vectors++;
      if (bus.x_flat !== exp_x()) begin miscompares++; $display("FAIL rnd_x cycle %0d got %h want %h", i, bus.x_flat, exp_x()); end
      vectors++;
      if (bus.h_flat !== exp_h()) begin miscompares++; $display("FAIL rnd_h cycle %0d got %h want %h", i, bus.h_flat, exp_h()); end
      vectors++;
      if (bus.win_valid !== m_win || bus.loaded !== m_loaded) begin
        miscompares++; $display("FAIL rnd_flags cycle %0d win=%b loaded=%b want %b %b", i, bus.win_valid, bus.loaded, m_win, m_loaded);
      end
`ifdef CORR_WIN_COUNT_EN
      vectors++;
      if (bus.win_count !== 16'(m_wcount)) begin
        miscompares++; $display("FAIL rnd_count cycle %0d got %0d want %0d", i, bus.win_count, m_wcount);
      end
`endif
    end
  endtask

`ifdef CORR_WIN_COUNT_EN
  task automatic test_win_count();
    apply_reset();
    load_random_coefs();
    for (int i = 0; i < TAPS + 19; i++) drive_cycle(0, 0, '0, 1, W'($urandom));
    vectors++;
    if (bus.win_count !== 16'd20) begin miscompares++; $display("FAIL count_20 got %0d want 20", bus.win_count); end
    drive_cycle(1, 0, '0, 0, '0);
    vectors++;
    if (bus.win_count !== 16'd0) begin miscompares++; $display("FAIL count_clear got %0d want 0", bus.win_count); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.coef_start = 0; bus.coef_valid = 0; bus.coef_data = '0;
    bus.s_valid = 0; bus.s_data = '0;
    model_reset();
    test_reset();
    test_load_and_fill();
    test_back_to_back();
    test_coef_start();
    test_reset_midload();
    test_fill_gaps();
    test_random();
`ifdef CORR_WIN_COUNT_EN
    test_win_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
